// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: round-robin arbiter sharing one synchronous FIFO write
// port between NUM_REQ producers. A granted producer keeps the port until its
// burst ends (req_last) or MAX_BURST beats have been written.
// Optional build macro FIFO_ARB_STATS_EN adds the beat_count/stall_count outputs.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no owner; pick next requester starting at rr_ptr
// ST_GRANT | grant_id owns the FIFO write port until release
module fifo_write_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8,
   parameter int MAX_BURST  = 8
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   input  logic [NUM_REQ-1:0]            req_last,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic                          fifo_full,
   output logic                          fifo_wr_en,
   output logic [DATA_WIDTH-1:0]         fifo_data_in,
   output logic [$clog2(NUM_REQ)-1:0]    grant_id,
   output logic                          busy
`ifdef FIFO_ARB_STATS_EN
   ,
   output logic [31:0]                   beat_count,
   output logic [31:0]                   stall_count
`endif
);

   localparam int GW = $clog2(NUM_REQ);
   localparam int CW = $clog2(MAX_BURST + 1);

   localparam logic ST_IDLE  = 1'b0;
   localparam logic ST_GRANT = 1'b1;

   logic                  state;
   logic [GW-1:0]         rr_ptr;
   logic [CW-1:0]         beat_cnt;

   logic                  pick_found;
   logic [GW-1:0]         pick_id;
   logic [GW-1:0]         cand;
   logic [GW-1:0]         rr_next;
   logic                  in_grant;
   logic                  burst_end;
   logic                  release_now;
   logic [DATA_WIDTH-1:0] slice [NUM_REQ];

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
      assign slice[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
   end

   // Round-robin search: first valid requester at or after rr_ptr.
   always_comb begin
      pick_found = 1'b0;
      pick_id    = '0;
      cand       = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = GW'((int'(rr_ptr) + k) % NUM_REQ);
         if (!pick_found && req_valid[cand]) begin
            pick_found = 1'b1;
            pick_id    = cand;
         end
      end
   end

   assign in_grant     = (state == ST_GRANT);
   assign fifo_wr_en   = in_grant & req_valid[grant_id] & ~fifo_full;
   assign fifo_data_in = fifo_wr_en ? slice[grant_id] : '0;
   assign burst_end    = (int'(beat_cnt) + 1 == MAX_BURST);
   assign release_now  = fifo_wr_en & (req_last[grant_id] | burst_end);
   assign rr_next      = (grant_id == GW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;

   // Only the owner sees ready, and only while the FIFO can take a beat.
   always_comb begin
      req_ready = '0;
      if (in_grant && !fifo_full) begin
         req_ready[grant_id] = 1'b1;
      end
   end

   // Arbitration FSM: one idle cycle to pick, then hold until release.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ST_IDLE;
         rr_ptr   <= '0;
         grant_id <= '0;
         beat_cnt <= '0;
         busy     <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (pick_found) begin
                  grant_id <= pick_id;
                  busy     <= 1'b1;
                  state    <= ST_GRANT;
               end
            end
            default: begin
               if (release_now) begin
                  rr_ptr   <= rr_next;
                  beat_cnt <= '0;
                  busy     <= 1'b0;
                  state    <= ST_IDLE;
               end else if (fifo_wr_en) begin
                  beat_cnt <= beat_cnt + 1'b1;
               end
            end
         endcase
      end
   end

`ifdef FIFO_ARB_STATS_EN
   // Free-running statistics; a stall is an owner with data blocked by full.
   always_ff @(posedge clk) begin
      if (reset) begin
         beat_count  <= '0;
         stall_count <= '0;
      end else begin
         if (fifo_wr_en) begin
            beat_count <= beat_count + 32'd1;
         end
         if (in_grant && req_valid[grant_id] && fifo_full) begin
            stall_count <= stall_count + 32'd1;
         end
      end
   end
`endif

endmodule
